// File: rtl/pc_sequencer.sv
// Program counter and call/return sequencer feeding return_stack.
// Tracks return-stack occupancy so overflow/underflow become visible flags.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          RS_DEPTH = 64
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  op,
  input  logic [15:0] target,
  input  logic        cond_zero,
  input  logic [15:0] rs_top,
  output logic [15:0] pc,
  output logic [1:0]  rs_op,
  output logic [15:0] rs_w,
  output logic [6:0]  rs_count,
  output logic        overflow,
  output logic        underflow,
  output logic        halted
);

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_BZ   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  localparam logic [1:0] RS_HOLD = 2'd0;
  localparam logic [1:0] RS_PUSH = 2'd1;
  localparam logic [1:0] RS_POP  = 2'd3;

  localparam logic [6:0] DEPTH = 7'(RS_DEPTH);

  logic        active;
  logic [15:0] pc_inc;
  logic [15:0] pc_next;
  logic [6:0]  count_next;
  logic        overflow_next;
  logic        underflow_next;
  logic        halted_next;

  assign active = !reset && !stall && !halted;
  assign pc_inc = pc + 16'd1;
  // The return stack sees RESET_PC+1 while it resets, whatever pc held before.
  assign rs_w   = reset ? (RESET_PC + 16'd1) : pc_inc;

  always_comb begin
    pc_next        = pc;
    count_next     = rs_count;
    overflow_next  = overflow;
    underflow_next = underflow;
    halted_next    = halted;
    rs_op          = RS_HOLD;
    if (active) begin
      case (op)
        OP_JUMP: pc_next = target;
        OP_BZ:   pc_next = cond_zero ? target : pc_inc;
        OP_CALL: begin
          rs_op   = RS_PUSH;
          pc_next = target;
          // At full depth return_stack drops its oldest entry; count saturates.
          if (rs_count < DEPTH) count_next = rs_count + 7'd1;
          else overflow_next = 1'b1;
        end
        OP_RET: begin
          rs_op = RS_POP;
          if (rs_count != 7'd0) begin
            count_next = rs_count - 7'd1;
            pc_next    = rs_top;
          end else begin
            underflow_next = 1'b1;
            halted_next    = 1'b1;
          end
        end
        OP_HALT: halted_next = 1'b1;
        default: pc_next = pc_inc;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pc        <= RESET_PC;
      rs_count  <= 7'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      halted    <= 1'b0;
    end else begin
      pc        <= pc_next;
      rs_count  <= count_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
      halted    <= halted_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural return_stack attached.
// Inputs change #1 after the rising edge; outputs are checked before the next edge.
module tb_pc_sequencer;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BZ = 3'd2, CALL = 3'd3, RET = 3'd4, HALT = 3'd5;

  logic        CLK = 1'b0;
  logic        reset, stall, cond_zero;
  logic [2:0]  op;
  logic [15:0] target, rs_top, pc, rs_w;
  logic [1:0]  rs_op;
  logic [6:0]  rs_count;
  logic        overflow, underflow, halted;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK(CLK), .reset(reset), .stall(stall), .op(op), .target(target),
    .cond_zero(cond_zero), .rs_top(rs_top), .pc(pc), .rs_op(rs_op),
    .rs_w(rs_w), .rs_count(rs_count), .overflow(overflow),
    .underflow(underflow), .halted(halted)
  );

  // return_stack model: drops the bottom entry on push when full, reads 0 when empty.
  logic [15:0] stk [64];
  int          sp = 0;

  always @(posedge CLK) begin
    if (reset) sp <= 0;
    else if (rs_op == 2'd1) begin
      if (sp < 64) begin
        stk[sp] <= rs_w;
        sp <= sp + 1;
      end else begin
        for (int i = 0; i < 63; i++) stk[i] <= stk[i+1];
        stk[63] <= rs_w;
      end
    end else if (rs_op == 2'd3 && sp > 0) sp <= sp - 1;
  end

  assign rs_top = (sp > 0) ? stk[sp-1] : 16'h0000;

  task automatic drive(input logic [2:0] o, input logic [15:0] t, input logic cz, input logic st);
    op = o; target = t; cond_zero = cz; stall = st;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(CALL, 16'h1234, 1'b0, 1'b0);
    total++; if (rs_op !== 2'd0) $display("FAIL reset_rs_op: got %0d expected 0", rs_op); else passed++;
    total++; if (rs_w !== 16'h0001) $display("FAIL reset_rs_w: got %h expected 0001", rs_w); else passed++;
    tick();
    tick();
    total++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h expected 0000", pc); else passed++;
    total++; if (rs_count !== 7'd0) $display("FAIL reset_count: got %0d expected 0", rs_count); else passed++;
    total++; if ({overflow, underflow, halted} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {overflow, underflow, halted}); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_next();
    for (int i = 1; i <= 3; i++) begin
      drive(NEXT, 16'h0000, 1'b0, 1'b0);
      total++; if (rs_op !== 2'd0) $display("FAIL next_rs_op: got %0d expected 0", rs_op); else passed++;
      tick();
      total++; if (pc !== 16'(i)) $display("FAIL next_pc: got %h expected %h", pc, 16'(i)); else passed++;
    end
    total++; if (rs_count !== 7'd0) $display("FAIL next_count: got %0d expected 0", rs_count); else passed++;
  endtask

  task automatic test_call_ret();
    drive(JUMP, 16'd5, 1'b0, 1'b0); tick();
    drive(CALL, 16'h0100, 1'b0, 1'b0);
    total++; if (rs_op !== 2'd1) $display("FAIL call_rs_op: got %0d expected 1", rs_op); else passed++;
    total++; if (rs_w !== 16'd6) $display("FAIL call_rs_w: got %h expected 0006", rs_w); else passed++;
    tick();
    total++; if (pc !== 16'h0100) $display("FAIL call_pc: got %h expected 0100", pc); else passed++;
    total++; if (rs_count !== 7'd1) $display("FAIL call_count: got %0d expected 1", rs_count); else passed++;
    total++; if (rs_top !== 16'd6) $display("FAIL call_rs_top: got %h expected 0006", rs_top); else passed++;
    drive(RET, 16'h0000, 1'b0, 1'b0);
    total++; if (rs_op !== 2'd3) $display("FAIL ret_rs_op: got %0d expected 3", rs_op); else passed++;
    tick();
    total++; if (pc !== 16'd6) $display("FAIL ret_pc: got %h expected 0006", pc); else passed++;
    total++; if (rs_count !== 7'd0) $display("FAIL ret_count: got %0d expected 0", rs_count); else passed++;
  endtask

  task automatic test_branch_stall();
    drive(JUMP, 16'd10, 1'b0, 1'b0); tick();
    drive(BZ, 16'd40, 1'b0, 1'b0); tick();
    total++; if (pc !== 16'd11) $display("FAIL bz_not_taken: got %h expected 000b", pc); else passed++;
    drive(JUMP, 16'd10, 1'b0, 1'b0); tick();
    drive(BZ, 16'd40, 1'b1, 1'b0); tick();
    total++; if (pc !== 16'd40) $display("FAIL bz_taken: got %h expected 0028", pc); else passed++;
    drive(JUMP, 16'hFFFF, 1'b0, 1'b0); tick();
    total++; if (pc !== 16'hFFFF) $display("FAIL jump_ffff: got %h expected ffff", pc); else passed++;
    total++; if (rs_w !== 16'h0000) $display("FAIL rs_w_wrap: got %h expected 0000", rs_w); else passed++;
    drive(NEXT, 16'h0000, 1'b0, 1'b0); tick();
    total++; if (pc !== 16'h0000) $display("FAIL pc_wrap: got %h expected 0000", pc); else passed++;
    drive(OP_SEVEN(), 16'h0000, 1'b0, 1'b0); tick();
    total++; if (pc !== 16'h0001) $display("FAIL op7_next: got %h expected 0001", pc); else passed++;
    drive(CALL, 16'h0300, 1'b0, 1'b1);
    total++; if (rs_op !== 2'd0) $display("FAIL stall_rs_op: got %0d expected 0", rs_op); else passed++;
    tick();
    total++; if (pc !== 16'h0001) $display("FAIL stall_pc: got %h expected 0001", pc); else passed++;
    total++; if (rs_count !== 7'd0) $display("FAIL stall_count: got %0d expected 0", rs_count); else passed++;
  endtask

  function automatic logic [2:0] OP_SEVEN();
    return 3'd7;
  endfunction

  task automatic test_back_to_back();
    drive(JUMP, 16'h0050, 1'b0, 1'b0); tick();
    drive(CALL, 16'h0200, 1'b0, 1'b0); tick();
    drive(RET, 16'h0000, 1'b0, 1'b0); tick();
    total++; if (pc !== 16'h0051) $display("FAIL b2b_pc: got %h expected 0051", pc); else passed++;
    total++; if (rs_count !== 7'd0) $display("FAIL b2b_count: got %0d expected 0", rs_count); else passed++;
  endtask

  // CALL #k sits at 0x1000+16*(k-1), so its return address is that plus one.
  task automatic test_overflow();
    logic [15:0] exp_ret;
    drive(JUMP, 16'h1000, 1'b0, 1'b0); tick();
    for (int k = 1; k <= 65; k++) begin
      drive(CALL, 16'(16'h1000 + 16 * k), 1'b0, 1'b0); tick();
      if (k == 64) begin
        total++; if (rs_count !== 7'd64) $display("FAIL ovf_count64: got %0d expected 64", rs_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b expected 0", overflow); else passed++;
      end
    end
    total++; if (rs_count !== 7'd64) $display("FAIL ovf_count65: got %0d expected 64", rs_count); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL ovf_halted: got %b expected 0", halted); else passed++;
    for (int i = 0; i < 64; i++) begin
      exp_ret = 16'(16'h1000 + 16 * (64 - i) + 1);
      drive(RET, 16'h0000, 1'b0, 1'b0); tick();
      total++; if (pc !== exp_ret) $display("FAIL ovf_ret_%0d: got %h expected %h", i, pc, exp_ret); else passed++;
    end
    total++; if (rs_count !== 7'd0) $display("FAIL ovf_drain_count: got %0d expected 0", rs_count); else passed++;
    total++; if (underflow !== 1'b0) $display("FAIL ovf_underflow: got %b expected 0", underflow); else passed++;
  endtask

  task automatic test_underflow();
    drive(RET, 16'h0000, 1'b0, 1'b0);
    total++; if (rs_op !== 2'd3) $display("FAIL unf_rs_op: got %0d expected 3", rs_op); else passed++;
    tick();
    total++; if (pc !== 16'h1011) $display("FAIL unf_pc: got %h expected 1011", pc); else passed++;
    total++; if ({overflow, underflow, halted} !== 3'b111) $display("FAIL unf_flags: got %b expected 111", {overflow, underflow, halted}); else passed++;
    drive(JUMP, 16'h0055, 1'b0, 1'b0); tick();
    total++; if (pc !== 16'h1011) $display("FAIL halt_jump: got %h expected 1011", pc); else passed++;
    drive(CALL, 16'h0077, 1'b0, 1'b0);
    total++; if (rs_op !== 2'd0) $display("FAIL halt_rs_op: got %0d expected 0", rs_op); else passed++;
    tick();
    total++; if (rs_count !== 7'd0) $display("FAIL halt_count: got %0d expected 0", rs_count); else passed++;
  endtask

  task automatic test_halt_op();
    reset = 1'b1; drive(NEXT, 16'h0000, 1'b0, 1'b0); tick(); reset = 1'b0;
    drive(NEXT, 16'h0000, 1'b0, 1'b0); tick();
    drive(HALT, 16'h0000, 1'b0, 1'b0); tick();
    total++; if (pc !== 16'h0001) $display("FAIL halt_op_pc: got %h expected 0001", pc); else passed++;
    total++; if ({underflow, halted} !== 2'b01) $display("FAIL halt_op_flags: got %b expected 01", {underflow, halted}); else passed++;
    drive(NEXT, 16'h0000, 1'b0, 1'b0); tick();
    total++; if (pc !== 16'h0001) $display("FAIL halt_op_hold: got %h expected 0001", pc); else passed++;
  endtask

  task automatic test_reset_recovery();
    reset = 1'b1; drive(NEXT, 16'h0000, 1'b0, 1'b0); tick(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(CALL, 16'(16'h0400 + k), 1'b0, 1'b0); tick();
    end
    total++; if (rs_count !== 7'd3) $display("FAIL rr_count_pre: got %0d expected 3", rs_count); else passed++;
    reset = 1'b1;
    drive(CALL, 16'h0999, 1'b0, 1'b0);
    total++; if (rs_op !== 2'd0) $display("FAIL rr_rs_op: got %0d expected 0", rs_op); else passed++;
    total++; if (rs_w !== 16'h0001) $display("FAIL rr_rs_w: got %h expected 0001", rs_w); else passed++;
    tick();
    reset = 1'b0;
    drive(NEXT, 16'h0000, 1'b0, 1'b1);
    total++; if (pc !== 16'h0000) $display("FAIL rr_pc: got %h expected 0000", pc); else passed++;
    total++; if (rs_count !== 7'd0) $display("FAIL rr_count: got %0d expected 0", rs_count); else passed++;
    total++; if ({overflow, underflow, halted} !== 3'b000) $display("FAIL rr_flags: got %b expected 000", {overflow, underflow, halted}); else passed++;
    total++; if (rs_top !== 16'h0000) $display("FAIL rr_rs_top: got %h expected 0000", rs_top); else passed++;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; op = NEXT; target = 16'h0000; cond_zero = 1'b0;
    #1;
    test_reset();
    test_next();
    test_call_ret();
    test_branch_stall();
    test_back_to_back();
    test_overflow();
    test_underflow();
    test_halt_op();
    test_reset_recovery();
    chk("final_pc_idle", pc, 16'h0000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and call/return sequencer for the stack processor, directly upstream of `return_stack`. It holds the PC and decodes the control-flow op from instruction decode. It generates the `stackOP` and `w` inputs of `return_stack` and consumes its `a` (top-of-stack) output. It also tracks return-stack occupancy, because `return_stack` silently drops its bottom entry on overflow and returns 0 on underflow.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `RS_DEPTH`, default 64: return-stack capacity; must match `return_stack`.
- `CLK` in 1: system clock, rising-edge active.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: when high, the op is ignored, all state holds and `rs_op`=0.
- `op` in 3: 0 NEXT, 1 JUMP, 2 BZ (branch if `cond_zero`), 3 CALL, 4 RET, 5 HALT; 6 and 7 behave as NEXT.
- `target` in 16: jump/branch/call destination.
- `cond_zero` in 1: BZ condition, sampled in the same cycle as the op.
- `rs_top` in 16: connected to `return_stack.a`.
- `pc` out 16: current program counter, registered.
- `rs_op` out 2: to `return_stack.stackOP`; 0 hold, 1 push, 3 pop; combinational.
- `rs_w` out 16: to `return_stack.w`; equals `pc + 1` (mod 2^16); combinational.
- `rs_count` out 7: number of valid return-stack entries, 0..`RS_DEPTH`, registered.
- `overflow` out 1: sticky; set by a CALL at full occupancy.
- `underflow` out 1: sticky; set by a RET at zero occupancy.
- `halted` out 1: sticky halt.

## Operation
- A cycle is **active** when `reset`=0, `stall`=0 and `halted`=0. In any non-active cycle, `pc`, `rs_count` and all flags hold, and `rs_op`=0.
- In an active cycle, the next `pc` is:
  - NEXT, or BZ with `cond_zero`=0: `pc+1`.
  - JUMP, or BZ with `cond_zero`=1: `target`.
  - CALL: `target`.
  - RET: `rs_top`.
  - HALT: `pc` (hold).
- `pc+1` wraps from 16'hFFFF to 16'h0000.
- CALL drives `rs_op`=1 with `rs_w`=`pc+1`.
  - If `rs_count` < `RS_DEPTH`, `rs_count` increments.
  - Otherwise `rs_count` stays at `RS_DEPTH` and `overflow` sets (the oldest return address is lost downstream). Execution continues.
- RET drives `rs_op`=3.
  - If `rs_count` > 0, `rs_count` decrements and `pc` takes `rs_top`.
  - If `rs_count`=0, `underflow` and `halted` set, `pc` holds, and `rs_op` is still 3 (harmless on an empty stack).
- HALT sets `halted`. Only `reset` clears `halted`, `overflow` or `underflow`.
- `rs_op` is never 2.
- During `reset`=1, `rs_op`=0 so that `return_stack` sees `stackOP`=0 while it resets.

## Timing
- Reset values: `pc`=`RESET_PC`, `rs_count`=0, `overflow`=0, `underflow`=0, `halted`=0. While reset is asserted, `rs_op`=0 and `rs_w`=`RESET_PC+1`.
- All registered state updates on the rising edge of `CLK` that ends the active cycle.
- Latency from op to new `pc` is 1 cycle.
- `return_stack` updates on the same edge. So after a CALL, `rs_top` shows the pushed address in the next cycle. On RET, `pc` captures the pre-pop `rs_top`.
- Back-to-back CALL/RET in consecutive cycles is legal. A RET immediately after a CALL returns to the CALL's `pc+1`.
- `stall` and `halted` gate `rs_op` combinationally, so no push or pop leaks in those cycles.
- Reset asserted mid-sequence takes priority over any op in that cycle.
- A RET at `rs_count`=0 halts. Halted is not a wait state: recovery is by reset only.
- `overflow` and `underflow` can both be set at once; they are independent.

## Test plan
- **Reset and NEXT:** reset, then 3 NEXT → `pc`=0,1,2,3; `rs_op`=0 throughout; `rs_count`=0.
- **Call/return:**
  - At `pc`=5, CALL with `target`=16'h0100 → `rs_op`=1 and `rs_w`=6 during the cycle; next cycle `pc`=16'h0100, `rs_count`=1, `rs_top`=6.
  - Then RET → `pc`=6, `rs_count`=0.
- **Branches and stall:**
  - BZ `target`=40 with `cond_zero`=0 at `pc`=10 → 11; with `cond_zero`=1 → 40.
  - JUMP `target`=16'hFFFF, then NEXT → `pc`=0.
  - `stall`=1 with a CALL presented → `pc`, `rs_count` unchanged and `rs_op`=0.
- **Overflow:**
  - 65 nested CALLs → `rs_count`=64, `overflow`=1 after the 65th.
  - Then 64 RETs → `pc` equals the return address of CALL #65 first, ..., CALL #2 last; `rs_count`=0; `underflow`=0.
- **Underflow:** RET at `rs_count`=0 → `underflow`=1, `halted`=1, `pc` unchanged; subsequent JUMPs are ignored.
- **Reset recovery:** reset asserted during a stream of CALLs → next cycle all outputs at reset values and `rs_op`=0 during the reset cycle; `return_stack.a`=0 afterwards.
